// File: rtl/snake_vga_pkg.sv
// Shared constants, colour IDs and FSM state type for the snake VGA frame-buffer clients.
package snake_vga_pkg;

  localparam int unsigned SPIXEL_X_WIDTH = 5;
  localparam int unsigned SPIXEL_Y_WIDTH = 5;
  localparam int unsigned SPIXEL_X_MAX   = 31;
  localparam int unsigned SPIXEL_Y_MAX   = 23;
  localparam int unsigned PIXEL_X_MAX    = 639;
  localparam int unsigned PIXEL_Y_MAX    = 479;
  localparam int unsigned ADDR_WIDTH     = 19;
  localparam int unsigned COLOR_ID_WIDTH = 8;

  localparam int unsigned LINE_STRIDE = PIXEL_X_MAX + 1;
  localparam int unsigned CELL_W      = LINE_STRIDE / (SPIXEL_X_MAX + 1);
  localparam int unsigned CELL_H      = (PIXEL_Y_MAX + 1) / (SPIXEL_Y_MAX + 1);
  localparam int unsigned OFFS_WIDTH  = 5;
  localparam int unsigned NUM_SAMPLES = 5;
  localparam int unsigned SIDX_WIDTH  = 3;

  localparam logic [COLOR_ID_WIDTH-1:0] COLOR_BG    = 8'h00;
  localparam logic [COLOR_ID_WIDTH-1:0] COLOR_BODY  = 8'h0f;
  localparam logic [COLOR_ID_WIDTH-1:0] COLOR_HEAD  = 8'hff;
  localparam logic [COLOR_ID_WIDTH-1:0] COLOR_APPLE = 8'hf9;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    ISSUE,
    DRAIN,
    DONE
  } rsp_state_e;

  // Linear offset of sample k from the cell origin: centre first, then the four inset corners.
  function automatic logic [ADDR_WIDTH-1:0] sample_offset(input logic [SIDX_WIDTH-1:0] k);
    int unsigned off;
    case (k)
      3'd0:    off = (CELL_H / 2) * LINE_STRIDE + CELL_W / 2;
      3'd1:    off = LINE_STRIDE + 1;
      3'd2:    off = LINE_STRIDE + CELL_W - 2;
      3'd3:    off = (CELL_H - 2) * LINE_STRIDE + 1;
      3'd4:    off = (CELL_H - 2) * LINE_STRIDE + CELL_W - 2;
      default: off = 0;
    endcase
    return ADDR_WIDTH'(off);
  endfunction

endpackage

// File: rtl/spixel_addr_calc.sv
// Combinational map from logical cell plus in-cell pixel offset to frame-buffer address.
module spixel_addr_calc
  import snake_vga_pkg::*;
(
  input  logic [SPIXEL_X_WIDTH-1:0] x,
  input  logic [SPIXEL_Y_WIDTH-1:0] y,
  input  logic [OFFS_WIDTH-1:0]     dx,
  input  logic [OFFS_WIDTH-1:0]     dy,
  output logic [ADDR_WIDTH-1:0]     addr_c
);

  logic [ADDR_WIDTH-1:0] px;
  logic [ADDR_WIDTH-1:0] py;

  always_comb begin
    px     = ADDR_WIDTH'(x) * ADDR_WIDTH'(CELL_W) + ADDR_WIDTH'(dx);
    py     = ADDR_WIDTH'(y) * ADDR_WIDTH'(CELL_H) + ADDR_WIDTH'(dy);
    addr_c = py * ADDR_WIDTH'(LINE_STRIDE) + px;
  end

endmodule

// File: rtl/read_superpixel.sv
// Reads five sample pixels of one 20x20 cell and reports its colour and whether the samples disagree.
module read_superpixel
  import snake_vga_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SPIXEL_X_WIDTH-1:0] x,
  input  logic [SPIXEL_Y_WIDTH-1:0] y,
  input  logic                      ireq,
  output logic                      obusy,
  output logic                      odone,
  output logic [COLOR_ID_WIDTH-1:0] odata,
  output logic                      omixed,
  output logic                      oerr,
  output logic [ADDR_WIDTH-1:0]     oaddr,
  output logic                      ordreq,
  input  logic [COLOR_ID_WIDTH-1:0] irdata
);

  rsp_state_e                  state_q, state_d;
  logic [SPIXEL_X_WIDTH-1:0]   x_q, x_d;
  logic [SPIXEL_Y_WIDTH-1:0]   y_q, y_d;
  logic [ADDR_WIDTH-1:0]       base_q, base_d;
  logic [SIDX_WIDTH-1:0]       issue_idx_q, issue_idx_d;
  logic [2:0]                  drain_cnt_q, drain_cnt_d;
  logic [RD_LATENCY-1:0]       vld_q, vld_d;
  logic [SIDX_WIDTH-1:0]       cap_idx_q, cap_idx_d;
  logic [COLOR_ID_WIDTH-1:0]   centre_q, centre_d;
  logic                        mixed_q, mixed_d;
  logic                        obusy_q, obusy_d;
  logic                        odone_q, odone_d;
  logic [COLOR_ID_WIDTH-1:0]   odata_q, odata_d;
  logic                        omixed_q, omixed_d;
  logic                        oerr_q, oerr_d;
  logic [ADDR_WIDTH-1:0]       oaddr_q, oaddr_d;
  logic                        ordreq_q, ordreq_d;

  logic [ADDR_WIDTH-1:0]       base_c;
  logic                        cap_vld;
  logic                        mixed_now;

  spixel_addr_calc u_addr_calc (
    .x      (x_q),
    .y      (y_q),
    .dx     (OFFS_WIDTH'(0)),
    .dy     (OFFS_WIDTH'(0)),
    .addr_c (base_c)
  );

  assign obusy  = obusy_q;
  assign odone  = odone_q;
  assign odata  = odata_q;
  assign omixed = omixed_q;
  assign oerr   = oerr_q;
  assign oaddr  = oaddr_q;
  assign ordreq = ordreq_q;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    base_d      = base_q;
    issue_idx_d = issue_idx_q;
    drain_cnt_d = drain_cnt_q;
    cap_idx_d   = cap_idx_q;
    centre_d    = centre_q;
    mixed_d     = mixed_q;
    odone_d     = 1'b0;
    odata_d     = odata_q;
    omixed_d    = omixed_q;
    oerr_d      = oerr_q;
    oaddr_d     = oaddr_q;
    ordreq_d    = 1'b0;

    // Read-data valid follows each issued read by exactly RD_LATENCY cycles.
    vld_d[0] = ordreq_q;
    for (int i = 1; i < int'(RD_LATENCY); i++) begin
      vld_d[i] = vld_q[i-1];
    end

    cap_vld   = vld_q[RD_LATENCY-1];
    mixed_now = mixed_q | (cap_vld && (cap_idx_q != '0) && (irdata != centre_q));
    if (cap_vld) begin
      if (cap_idx_q == '0) centre_d = irdata;
      mixed_d   = mixed_now;
      cap_idx_d = SIDX_WIDTH'(cap_idx_q + 3'd1);
    end

    case (state_q)
      IDLE: begin
        if (ireq) begin
          x_d       = x;
          y_d       = y;
          cap_idx_d = '0;
          mixed_d   = 1'b0;
          if ((32'(y) > SPIXEL_Y_MAX) || (32'(x) > SPIXEL_X_MAX)) begin
            state_d  = DONE;
            odone_d  = 1'b1;
            oerr_d   = 1'b1;
            odata_d  = '0;
            omixed_d = 1'b0;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        base_d      = base_c;
        oaddr_d     = base_c + sample_offset(3'd0);
        ordreq_d    = 1'b1;
        issue_idx_d = '0;
        state_d     = ISSUE;
      end
      ISSUE: begin
        if (issue_idx_q == SIDX_WIDTH'(NUM_SAMPLES - 1)) begin
          drain_cnt_d = '0;
          state_d     = DRAIN;
        end else begin
          issue_idx_d = SIDX_WIDTH'(issue_idx_q + 3'd1);
          oaddr_d     = base_q + sample_offset(SIDX_WIDTH'(issue_idx_q + 3'd1));
          ordreq_d    = 1'b1;
        end
      end
      DRAIN: begin
        // The last sample lands in the final drain cycle, so fold it in directly.
        if (drain_cnt_q == 3'(RD_LATENCY - 1)) begin
          state_d  = DONE;
          odone_d  = 1'b1;
          odata_d  = centre_q;
          omixed_d = mixed_now;
          oerr_d   = 1'b0;
        end else begin
          drain_cnt_d = 3'(drain_cnt_q + 3'd1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    obusy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      base_q      <= '0;
      issue_idx_q <= '0;
      drain_cnt_q <= '0;
      vld_q       <= '0;
      cap_idx_q   <= '0;
      centre_q    <= '0;
      mixed_q     <= 1'b0;
      obusy_q     <= 1'b0;
      odone_q     <= 1'b0;
      odata_q     <= '0;
      omixed_q    <= 1'b0;
      oerr_q      <= 1'b0;
      oaddr_q     <= '0;
      ordreq_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      base_q      <= base_d;
      issue_idx_q <= issue_idx_d;
      drain_cnt_q <= drain_cnt_d;
      vld_q       <= vld_d;
      cap_idx_q   <= cap_idx_d;
      centre_q    <= centre_d;
      mixed_q     <= mixed_d;
      obusy_q     <= obusy_d;
      odone_q     <= odone_d;
      odata_q     <= odata_d;
      omixed_q    <= omixed_d;
      oerr_q      <= oerr_d;
      oaddr_q     <= oaddr_d;
      ordreq_q    <= ordreq_d;
    end
  end

endmodule
